// File: rtl/card_deck_if.sv
// Deck interface between the card source and its consumer.
// Latency: none, wires only.
// Backpressure: none. Requests are single-cycle pulses and there is no ready signal.
//
// Signals:
//   shuffle_req, card_req            : consumer -> deck request pulses
//   card_out, card_valid             : dealt card and its one-cycle strobe
//   shuffle_ok, deck_empty, busy,
//   cards_left                       : deck -> consumer status
interface card_deck_if #(
  parameter int CARD_W = 5
);
  logic              shuffle_req;
  logic              card_req;
  logic [CARD_W-1:0] card_out;
  logic              card_valid;
  logic              shuffle_ok;
  logic              deck_empty;
  logic              busy;
  logic [5:0]        cards_left;

  modport master (
    output shuffle_req, card_req,
    input  card_out, card_valid, shuffle_ok, deck_empty, busy, cards_left
  );

  modport slave (
    input  shuffle_req, card_req,
    output card_out, card_valid, shuffle_ok, deck_empty, busy, cards_left
  );
endinterface

// File: rtl/card_deck.sv
// 52-card deck with an LFSR-driven in-place Fisher-Yates shuffle and an in-order dealer.
// Latency: card one cycle after card_req; shuffle_ok at least 51 cycles after shuffle_req.
// Backpressure: none. Requests arriving in a state that cannot serve them are dropped, not queued.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of card_deck_if (requests in; card and status out)
module card_deck #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CARD_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  card_deck_if.slave  bus
);

  localparam int          NCARDS    = 52;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    READY   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        deck_q [NCARDS];
  logic [3:0]        deck_d [NCARDS];
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        top_q, top_d;
  logic [5:0]        left_q, left_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [CARD_W-1:0] card_out_q, card_out_d;
  logic              card_valid_q, card_valid_d;
  logic              shuffle_ok_q, shuffle_ok_d;
  logic              deck_empty_q, deck_empty_d;
  logic [5:0]        cand_j;

  // Ordered value at deck position k. Each suit is 13 cards: A..10, then J/Q/K all worth 11.
  function automatic logic [3:0] ordered_val(input int k);
    int r;
    r = k % 13;
    return (r < 10) ? 4'(r + 1) : 4'd11;
  endfunction

  always_comb begin
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    state_d      = state_q;
    deck_d       = deck_q;
    idx_d        = idx_q;
    top_d        = top_q;
    left_d       = left_q;
    card_out_d   = card_out_q;
    card_valid_d = 1'b0;
    shuffle_ok_d = 1'b0;
    deck_empty_d = deck_empty_q;
    cand_j       = lfsr_q[5:0];

    case (state_q)
      IDLE: begin
        if (bus.shuffle_req) begin
          state_d = SHUFFLE;
          idx_d   = 6'd51;
        end
      end

      SHUFFLE: begin
        // A candidate above the current index is rejected and retried next cycle.
        // Rejecting instead of folding the value keeps the draw unbiased.
        if (cand_j <= idx_q) begin
          deck_d[idx_q]  = deck_q[cand_j];
          deck_d[cand_j] = deck_q[idx_q];
          if (idx_q == 6'd1) begin
            state_d      = READY;
            top_d        = 6'd0;
            left_d       = 6'(NCARDS);
            shuffle_ok_d = 1'b1;
          end else begin
            idx_d = idx_q - 6'd1;
          end
        end
      end

      READY: begin
        // A shuffle request wins over a card request in the same cycle.
        if (bus.shuffle_req) begin
          state_d      = SHUFFLE;
          idx_d        = 6'd51;
          deck_empty_d = 1'b0;
        end else if (bus.card_req && (top_q < 6'(NCARDS))) begin
          card_out_d   = {{(CARD_W-4){1'b0}}, deck_q[top_q]};
          card_valid_d = 1'b1;
          top_d        = top_q + 6'd1;
          left_d       = left_q - 6'd1;
          deck_empty_d = (top_q == 6'(NCARDS - 1));
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int k = 0; k < NCARDS; k++) begin
        deck_q[k] <= ordered_val(k);
      end
      idx_q        <= 6'd51;
      top_q        <= 6'd0;
      left_q       <= 6'(NCARDS);
      lfsr_q       <= LFSR_SEED;
      card_out_q   <= '0;
      card_valid_q <= 1'b0;
      shuffle_ok_q <= 1'b0;
      deck_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      deck_q       <= deck_d;
      idx_q        <= idx_d;
      top_q        <= top_d;
      left_q       <= left_d;
      lfsr_q       <= lfsr_d;
      card_out_q   <= card_out_d;
      card_valid_q <= card_valid_d;
      shuffle_ok_q <= shuffle_ok_d;
      deck_empty_q <= deck_empty_d;
    end
  end

  assign bus.card_out   = card_out_q;
  assign bus.card_valid = card_valid_q;
  assign bus.shuffle_ok = shuffle_ok_q;
  assign bus.deck_empty = deck_empty_q;
  assign bus.busy       = (state_q == SHUFFLE);
  assign bus.cards_left = left_q;

endmodule
